// File: rtl/pe_ctx_sequencer.sv
// Per-PE context sequencer: loads 64-bit context words over a valid/ready port
// and replays them onto the register-file control fields for N passes.
module pe_ctx_sequencer #(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [63:0] cfg_data,
  input  logic        cfg_last,
  input  logic        start,
  input  logic [15:0] iter_count,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic [8:0]  control_in,
  output logic [8:0]  control_out,
  output logic [5:0]  control_put_in,
  output logic [5:0]  control_put_out,
  output logic [5:0]  control_reg_1,
  output logic [5:0]  control_reg_2,
  output logic [5:0]  control_send,
  output logic [3:0]  control_pe2fu_1,
  output logic [3:0]  control_pe2fu_2,
  output logic        write_back,
  output logic        ld,
  output logic        ld_write
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // NOP keeps the register file in load mode with every write enable low
  localparam logic [58:0] NOP_WORD = 59'(1) << 57;

  state_t            state, state_nx;
  logic [58:0]       ctx [CTX_DEPTH];
  logic [CTX_AW-1:0] wptr, pc;
  logic [CTX_AW:0]   len;
  logic [15:0]       iters;
  logic              loaded;
  logic [58:0]       word_q, word_nx;
  logic              busy_q, done_q;
  logic              accept, last_word, start_ok, pc_last;
  logic              unused_hi;

  assign unused_hi = ^cfg_data[63:59];

  assign cfg_ready = (state == IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign last_word = cfg_last || (wptr == CTX_AW'(CTX_DEPTH - 1));
  // a config accept in the same cycle takes precedence over start
  assign start_ok  = start && loaded && (iter_count != '0) && !accept;
  assign pc_last   = ({1'b0, pc} == (len - 1'b1));

  always_comb begin
    state_nx = state;
    word_nx  = NOP_WORD;
    case (state)
      IDLE: if (start_ok) state_nx = RUN;
      RUN: begin
        if (!stall) begin
          word_nx = ctx[pc];
          if (pc_last && (iters == 16'd1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept) ctx[wptr] <= cfg_data[58:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      wptr   <= '0;
      pc     <= '0;
      len    <= '0;
      iters  <= '0;
      loaded <= 1'b0;
      word_q <= NOP_WORD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      word_q <= word_nx;
      busy_q <= (state != IDLE);
      done_q <= (state == DONE);
      if (accept) begin
        if (last_word) begin
          len    <= {1'b0, wptr} + 1'b1;
          wptr   <= '0;
          loaded <= 1'b1;
        end else begin
          wptr   <= wptr + 1'b1;
          loaded <= 1'b0;
        end
      end
      if ((state == IDLE) && start_ok) begin
        pc    <= '0;
        iters <= iter_count;
      end else if ((state == RUN) && !stall) begin
        if (pc_last) begin
          pc    <= '0;
          iters <= iters - 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign control_in      = word_q[8:0];
  assign control_out     = word_q[17:9];
  assign control_put_in  = word_q[23:18];
  assign control_put_out = word_q[29:24];
  assign control_reg_1   = word_q[35:30];
  assign control_reg_2   = word_q[41:36];
  assign control_send    = word_q[47:42];
  assign control_pe2fu_1 = word_q[51:48];
  assign control_pe2fu_2 = word_q[55:52];
  assign write_back      = word_q[56];
  assign ld              = word_q[57];
  assign ld_write        = word_q[58];

endmodule
